toggle_counter: RTL and testbench

Switching-activity monitor for netlists built from the primitive cell library (BUF, NOT, NAND, NOR, DFF). It sits directly downstream of a cell netlist and samples a vector of monitored nets on every clock edge. Over an armed measurement window it accumulates the number of bit transitions, then presents the saturating total through a valid/acknowledge handshake. Used for bit-accurate activity and power characterisation of gate-level blocks.

---
 rtl/toggle_counter.sv | 67 ++++++
 tb/tb_toggle_counter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_counter.sv
// toggle_counter: counts bit transitions on S across a START..STOP window,
// saturating at 2^CNT_W-1, and holds the total on COUNT until ACK.
module toggle_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             C,
  input  logic             RN,
  input  logic [WIDTH-1:0] S,
  input  logic             START,
  input  logic             STOP,
  input  logic             ACK,
  output logic [CNT_W-1:0] COUNT,
  output logic             VALID,
  output logic             BUSY,
  output logic             SAT
);
  localparam int PW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] diff;
  logic [PW-1:0]    d;
  logic [CNT_W:0]   sum;
  assign diff = S ^ prev;
  always_comb begin
    d = '0;
    for (int i = 0; i < WIDTH; i++) d = d + PW'(diff[i]);
  end
  // One extra bit so the carry out flags the saturating clamp.
  assign sum = {1'b0, COUNT} + (CNT_W + 1)'(d);
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      COUNT <= '0;
      VALID <= 1'b0;
      BUSY  <= 1'b0;
      SAT   <= 1'b0;
      prev  <= '0;
    end else begin
      case (state)
        IDLE: if (START) begin
          state <= RUN;
          BUSY  <= 1'b1;
          prev  <= S;
          COUNT <= '0;
          SAT   <= 1'b0;
        end
        RUN: begin
          prev  <= S;
          COUNT <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
          if (sum[CNT_W]) SAT <= 1'b1;
          if (STOP) begin
            state <= HOLD;
            BUSY  <= 1'b0;
            VALID <= 1'b1;
          end
        end
        HOLD: if (ACK) begin
          state <= IDLE;
          VALID <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_toggle_counter.sv
// tb_toggle_counter: directed scenarios plus randomized traffic against a
// transition-counting reference model (CNT_W=8 so saturation is reachable).
module tb_toggle_counter;
  logic       C = 1'b0;
  logic       RN = 1'b0;
  logic [7:0] S = '0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       ACK = 1'b0;
  logic [7:0] COUNT;
  logic       VALID, BUSY, SAT;
  int n_cmp = 0;
  int n_err = 0;
  int m_mode = 0;
  int m_cnt = 0;
  logic m_sat = 1'b0;
  logic [7:0] m_prev = '0;

  toggle_counter #(.WIDTH(8), .CNT_W(8)) dut (
    .C(C), .RN(RN), .S(S), .START(START), .STOP(STOP), .ACK(ACK),
    .COUNT(COUNT), .VALID(VALID), .BUSY(BUSY), .SAT(SAT)
  );

  always #5 C = ~C;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: mode 0 idle, 1 counting, 2 holding; count is plain integer arithmetic.
  task automatic model_edge(input logic [7:0] s, input logic st, sp, ak);
    int t;
    if (!RN) return;
    if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_prev = s; m_cnt = 0; m_sat = 1'b0; end
    end else if (m_mode == 1) begin
      t = m_cnt + $countones(s ^ m_prev);
      m_prev = s;
      if (t > 255) begin m_cnt = 255; m_sat = 1'b1; end else m_cnt = t;
      if (sp) m_mode = 2;
    end else if (ak) m_mode = 0;
  endtask

  task automatic step(input logic [7:0] s, input logic st, sp, ak);
    @(negedge C);
    S = s; START = st; STOP = sp; ACK = ak;
    @(posedge C);
    model_edge(s, st, sp, ak);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_sat = 1'b0; m_prev = '0;
  endtask

  task automatic test_reset();
    RN = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(8'($urandom), 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({COUNT, VALID, BUSY, SAT} !== 11'd0) begin
        n_err++;
        $display("FAIL reset_hold: got cnt=%0d v=%b b=%b s=%b want all 0", COUNT, VALID, BUSY, SAT);
      end
    end
    @(negedge C); RN = 1'b1; START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(8'($urandom), 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({COUNT, VALID, BUSY, SAT} !== 11'd0) begin
        n_err++;
        $display("FAIL reset_release: got cnt=%0d v=%b b=%b s=%b want all 0", COUNT, VALID, BUSY, SAT);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] pat [3] = '{8'hFF, 8'h00, 8'h0F};
    logic [7:0] exp [3] = '{8'd8, 8'd16, 8'd20};
    step(8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({COUNT, VALID, BUSY, SAT} !== {8'd0, 3'b010}) begin
      n_err++;
      $display("FAIL basic_start: got cnt=%0d v=%b b=%b s=%b want cnt=0 b=1", COUNT, VALID, BUSY, SAT);
    end
    for (int i = 0; i < 3; i++) begin
      step(pat[i], 1'b0, i == 2, 1'b0);
      n_cmp++;
      if (COUNT !== exp[i]) begin
        n_err++;
        $display("FAIL basic_step%0d: got cnt=%0d want %0d", i, COUNT, exp[i]);
      end
    end
    n_cmp++;
    if ({COUNT, VALID, BUSY, SAT} !== {8'd20, 3'b100}) begin
      n_err++;
      $display("FAIL basic_final: got cnt=%0d v=%b b=%b s=%b want cnt=20 v=1", COUNT, VALID, BUSY, SAT);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) step(8'($urandom), i == 5, 1'b0, 1'b0);
    n_cmp++;
    if ({COUNT, VALID, BUSY} !== {8'd20, 2'b10}) begin
      n_err++;
      $display("FAIL hold_stable: got cnt=%0d v=%b b=%b want cnt=20 v=1 b=0", COUNT, VALID, BUSY);
    end
    step(8'h3C, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({COUNT, VALID, BUSY} !== {8'd20, 2'b00}) begin
      n_err++;
      $display("FAIL hold_ack: got cnt=%0d v=%b b=%b want cnt=20 v=0 b=0", COUNT, VALID, BUSY);
    end
    step(8'h3C, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({COUNT, VALID, BUSY, SAT} !== {8'd0, 3'b010}) begin
      n_err++;
      $display("FAIL hold_restart: got cnt=%0d v=%b b=%b s=%b want cnt=0 b=1", COUNT, VALID, BUSY, SAT);
    end
    step(8'h3C, 1'b0, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    step(8'h00, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 40; e++) begin
      step((e % 2) ? 8'hFF : 8'h00, 1'b0, e == 40, 1'b0);
      if (e == 31) begin
        n_cmp++;
        if ({COUNT, SAT} !== {8'd248, 1'b0}) begin
          n_err++;
          $display("FAIL sat_e31: got cnt=%0d s=%b want cnt=248 s=0", COUNT, SAT);
        end
      end
      if (e == 32) begin
        n_cmp++;
        if ({COUNT, SAT} !== {8'd255, 1'b1}) begin
          n_err++;
          $display("FAIL sat_e32: got cnt=%0d s=%b want cnt=255 s=1", COUNT, SAT);
        end
      end
    end
    n_cmp++;
    if ({COUNT, VALID, BUSY, SAT} !== {8'd255, 3'b101}) begin
      n_err++;
      $display("FAIL sat_final: got cnt=%0d v=%b b=%b s=%b want cnt=255 v=1 s=1", COUNT, VALID, BUSY, SAT);
    end
    step(8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0, 1'b0);
    step(8'h0F, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({COUNT, BUSY} !== {8'd12, 1'b1}) begin
      n_err++;
      $display("FAIL arst_pre: got cnt=%0d b=%b want cnt=12 b=1", COUNT, BUSY);
    end
    #1 RN = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({COUNT, VALID, BUSY, SAT} !== 11'd0) begin
      n_err++;
      $display("FAIL arst_immediate: got cnt=%0d v=%b b=%b s=%b want all 0", COUNT, VALID, BUSY, SAT);
    end
    @(negedge C); RN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(8'($urandom), 1'b0, i == 1, 1'b0);
      n_cmp++;
      if ({VALID, BUSY} !== 2'b00) begin
        n_err++;
        $display("FAIL arst_after: got v=%b b=%b want 0 0", VALID, BUSY);
      end
    end
  endtask

  task automatic test_edges();
    step(8'h55, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({COUNT, VALID, BUSY, SAT} !== 11'd0) begin
      n_err++;
      $display("FAIL edge_stop_idle: got cnt=%0d v=%b b=%b s=%b want all 0", COUNT, VALID, BUSY, SAT);
    end
    step(8'h55, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({VALID, BUSY} !== 2'b01) begin
      n_err++;
      $display("FAIL edge_start_stop: got v=%b b=%b want v=0 b=1", VALID, BUSY);
    end
    step(8'h55, 1'b0, 1'b1, 1'b0);
    step(8'h55, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    step(8'h81, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({COUNT, VALID, BUSY} !== {8'd2, 2'b10}) begin
      n_err++;
      $display("FAIL edge_min_window: got cnt=%0d v=%b b=%b want cnt=2 v=1", COUNT, VALID, BUSY);
    end
    step(8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      step(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 2) == 0);
      n_cmp++;
      if ({COUNT, VALID, BUSY, SAT} !== {8'(m_cnt), m_mode == 2, m_mode == 1, m_sat}) begin
        n_err++;
        if (bad++ < 10)
          $display("FAIL random_%0d: got cnt=%0d v=%b b=%b s=%b want cnt=%0d v=%b b=%b s=%b",
                   i, COUNT, VALID, BUSY, SAT, m_cnt, m_mode == 2, m_mode == 1, m_sat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_saturation();
    test_async_reset();
    test_edges();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
